// File: rtl/dataint_checksum_framed.sv
// Framed checksum engine: reduces keep-masked lanes each beat into an ADD, one's-complement or XOR
// accumulator, and holds the per-frame result until the consumer takes it.
//
//   state  | meaning
//   IDLE   | no frame open; next accepted beat starts a frame
//   ACTIVE | frame open; mode latched, accumulating beats
//   DONE   | result held on m_*; input stalled until m_ready
module dataint_checksum_framed #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [1:0]             cfg_mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic [LANES-1:0]       s_keep,
  input  logic                   s_last,
  input  logic [WIDTH-1:0]       exp_chksum,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_chksum,
  output logic                   m_match,
  output logic [CNT_W-1:0]       m_beats,
  output logic                   m_mode_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] MODE_ONES = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Four guard bits hold the carries of up to eight lanes plus the running value.
  localparam int SUM_W = WIDTH + 4;

  logic [1:0]       state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             first_beat;
  logic [1:0]       mode_eff;
  logic [WIDTH-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [SUM_W-1:0] lane_sum;
  logic [WIDTH-1:0] lane_xor;
  logic [SUM_W-1:0] fold1;
  logic [WIDTH-1:0] fold2;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] chk_next;
  logic [CNT_W-1:0] cnt_next;

  assign accept  = s_valid && s_ready;
  assign m_valid = (state == ST_DONE);

  always_comb begin
    first_beat = (state == ST_IDLE);
    mode_eff   = first_beat ? cfg_mode : mode_q;
    acc_base   = first_beat ? '0 : acc;
    cnt_base   = first_beat ? '0 : cnt;

    lane_sum = SUM_W'(acc_base);
    lane_xor = acc_base;
    for (int i = 0; i < LANES; i++) begin
      if (s_keep[i]) begin
        lane_sum = lane_sum + SUM_W'(s_data[i*WIDTH +: WIDTH]);
        lane_xor = lane_xor ^ s_data[i*WIDTH +: WIDTH];
      end
    end

    // Two end-around folds: after the first the carry-out can be at most one.
    fold1 = SUM_W'(lane_sum[WIDTH-1:0]) + SUM_W'(lane_sum[SUM_W-1:WIDTH]);
    fold2 = fold1[WIDTH-1:0] + WIDTH'(fold1[SUM_W-1:WIDTH]);

    case (mode_eff)
      MODE_ONES: acc_next = fold2;
      MODE_XOR:  acc_next = lane_xor;
      default:   acc_next = lane_sum[WIDTH-1:0];
    endcase

    chk_next = (mode_eff == MODE_ONES) ? ~acc_next : acc_next;
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      mode_q     <= '0;
      acc        <= '0;
      cnt        <= '0;
      m_chksum   <= '0;
      m_match    <= 1'b0;
      m_beats    <= '0;
      m_mode_err <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b1;
      mode_q     <= '0;
      acc        <= '0;
      cnt        <= '0;
      m_chksum   <= '0;
      m_match    <= 1'b0;
      m_beats    <= '0;
      m_mode_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACTIVE: begin
          s_ready <= 1'b1;
          if (accept) begin
            acc    <= acc_next;
            cnt    <= cnt_next;
            mode_q <= mode_eff;
            if (s_last) begin
              state      <= ST_DONE;
              s_ready    <= 1'b0;
              m_chksum   <= chk_next;
              m_match    <= (chk_next == exp_chksum);
              m_beats    <= cnt_next;
              m_mode_err <= (mode_eff == MODE_RSVD);
            end else begin
              state <= ST_ACTIVE;
            end
          end
        end
        ST_DONE: begin
          if (m_ready) begin
            state   <= ST_IDLE;
            s_ready <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
